// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter.
//
// Sends one command byte to the attached PS/2 device over the shared
// open-drain ps2_clk/ps2_data lines. It pulls the lines low only while a
// frame is in flight and releases them at all other times, so it can sit
// beside a PS/2 receiver on the same pads.
//
// Frame: inhibit (clock held low), request-to-send (data low, clock
// released), then the device clocks out start 0, d0..d7 LSB first, odd
// parity and stop 1. The device then ACKs by holding data low for one
// more clock.
//
// Ports
//   clk, rst_n       system clock, asynchronous active-low reset
//   ps2_clk/data     raw line levels (asynchronous to clk)
//   ps2_clk_oe       1 = pull ps2_clk low, 0 = release
//   ps2_data_oe      1 = pull ps2_data low, 0 = release
//   tx_data          byte to send, captured when tx_start is accepted
//   tx_start         one-cycle request, honoured only when idle
//   busy             high from the cycle after acceptance until idle again
//   done             one-cycle pulse: frame sent and ACK seen
//   err              one-cycle pulse: no ACK, or device clock timeout
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RTS       = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  // Line synchronizers. They reset to 1 (idle bus level) so that leaving
  // reset never looks like a falling clock edge.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fe;

  logic [2:0]       state_q,   state_d;
  logic [9:0]       shreg_q,   shreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
  logic             clk_oe_q,  clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;
  logic             timed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign fe = clk_prev_q & ~clk_sync_q;

  // States in which the device owns the clock and may stall forever.
  assign timed = (state_q == S_SEND) || (state_q == S_ACK) ||
                 (state_q == S_WAIT_IDLE);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_start) begin
          // Stop and parity ride in the shift register behind the data;
          // the start bit is driven directly in RTS.
          shreg_d   = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      S_RTS: begin
        // Start bit stays on data; handing the clock to the device.
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        state_d   = S_SEND;
      end

      S_SEND: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (fe) begin
          to_cnt_d  = '0;
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b0, shreg_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          // The 10th edge puts the stop bit (released line) out.
          if (bit_cnt_q == 4'd9) state_d = S_ACK;
        end
      end

      S_ACK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (fe) begin
          to_cnt_d = '0;
          if (!data_sync_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            err_d     = 1'b1;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (fe) to_cnt_d = '0;
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Device stall: abandon the frame. A falling edge this cycle restarts
    // the window, so it pre-empts the timeout.
    if (timed && !fe && (to_cnt_q == TO_LAST)) begin
      done_d    = 1'b0;
      err_d     = 1'b1;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Line enables come straight from flops so the pads never glitch.
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  // done/err are registered alongside the return to IDLE, so busy drops
  // in the same cycle as the pulse.
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed bench for ps2_tx with a PS/2 device model that
// clocks the frame, samples line bits on rising clock edges and ACKs.
module tb_ps2_tx;

  localparam int INH = 50;
  localparam int TO  = 400;
  localparam int H   = 20;   // device half clock period in clk cycles

  logic       clk;
  logic       rst_n;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy, done, err;
  logic       dev_clk_low, dev_data_low;
  logic       line_clk, line_data;

  // Open-drain bus: low if either side pulls, otherwise pulled up.
  assign line_clk  = ~(ps2_clk_oe  | dev_clk_low);
  assign line_data = ~(ps2_data_oe | dev_data_low);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps2_clk(line_clk), .ps2_data(line_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int busy_bad = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (done === 1'b1 && err === 1'b1) both_cnt++;
    if ((done === 1'b1 || err === 1'b1) && busy !== 1'b0) busy_bad++;
  end

  // Issue a request and follow it through inhibit and RTS.
  task automatic run_to_send(input logic [7:0] b, output int inh_n,
                             output logic rts_ok, output logic send_ok);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    inh_n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && inh_n < 4*INH) begin
      inh_n++;
      @(negedge clk);
    end
    rts_ok = (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1);
    @(negedge clk);
    send_ok = (ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1);
  endtask

  // Device model. bits = {stop, parity, d7..d0, start}. stop_after > 0
  // returns right after that falling edge with the clock still held low;
  // poke_at > 0 pulses tx_start with 0x55 during that clock-low phase.
  task automatic dev_frame(input logic do_ack, input int stop_after,
                           input int poke_at, output logic [10:0] bits,
                           output logic ok);
    int n;
    ok = 1'b1;
    bits = '0;
    n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 4*INH + 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4*INH + 100) begin
      ok = 1'b0;
      return;
    end
    repeat (H) @(negedge clk);
    bits[0] = line_data;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && do_ack) begin
        dev_data_low = 1'b1;
        repeat (H) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (k == stop_after) begin
        repeat (H/2) @(negedge clk);
        return;
      end
      if (k == poke_at) begin
        @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (H-2) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = line_data;
      repeat (H) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, err} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {ps2_clk_oe, ps2_data_oe, busy, done, err});
    else n_pass++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, err} !== 5'b0)
      $display("FAIL idle_after_reset: got %b want 00000", {ps2_clk_oe, ps2_data_oe, busy, done, err});
    else n_pass++;
  endtask

  task automatic test_send_ed;
    int inh_n, d0, e0;
    logic rts_ok, send_ok, ok;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    run_to_send(8'hED, inh_n, rts_ok, send_ok);
    n_checks++;
    if (inh_n !== INH) $display("FAIL ed_inhibit_len: got %0d want %0d", inh_n, INH);
    else n_pass++;
    n_checks++;
    if (rts_ok !== 1'b1) $display("FAIL ed_rts: got %b want 1", rts_ok);
    else n_pass++;
    n_checks++;
    if (send_ok !== 1'b1 || busy !== 1'b1)
      $display("FAIL ed_send_entry: got send=%b busy=%b want 1 1", send_ok, busy);
    else n_pass++;
    dev_frame(1'b1, 0, 0, bits, ok);
    repeat (10) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1 || bits !== 11'b1_1_11101101_0)
      $display("FAIL ed_bits: got ok=%b %b want 1 11111011010", ok, bits);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL ed_done: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b0)
      $display("FAIL ed_idle: got %b want 000", {ps2_clk_oe, ps2_data_oe, busy});
    else n_pass++;
  endtask

  task automatic test_send_f4;
    int inh_n, d0, e0;
    logic rts_ok, send_ok, ok;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    run_to_send(8'hF4, inh_n, rts_ok, send_ok);
    dev_frame(1'b1, 0, 0, bits, ok);
    repeat (10) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1 || bits !== 11'b1_0_11110100_0)
      $display("FAIL f4_bits: got ok=%b %b want 1 10111101000", ok, bits);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL f4_done: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_no_ack;
    int inh_n, d0, e0;
    logic rts_ok, send_ok, ok;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    run_to_send(8'h00, inh_n, rts_ok, send_ok);
    dev_frame(1'b0, 0, 0, bits, ok);
    repeat (10) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1 || bits !== 11'b1_1_00000000_0)
      $display("FAIL noack_bits: got ok=%b %b want 1 11000000000", ok, bits);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1)
      $display("FAIL noack_err: got done=%0d err=%0d want 0 1", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b0)
      $display("FAIL noack_release: got %b want 000", {ps2_clk_oe, ps2_data_oe, busy});
    else n_pass++;
  endtask

  task automatic test_timeout;
    int inh_n, n, d0;
    logic rts_ok, send_ok;
    d0 = done_cnt;
    run_to_send(8'h12, inh_n, rts_ok, send_ok);
    // Current sample is the first cycle with the clock released.
    n = 0;
    while (err !== 1'b1 && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== TO) $display("FAIL timeout_latency: got %0d want %0d", n, TO);
    else n_pass++;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b0)
      $display("FAIL timeout_release: got %b want 000", {ps2_clk_oe, ps2_data_oe, busy});
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 0) $display("FAIL timeout_no_done: got %0d want 0", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    int inh_n, d0, e0;
    logic rts_ok, send_ok, ok;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    run_to_send(8'hA6, inh_n, rts_ok, send_ok);
    dev_frame(1'b1, 0, 3, bits, ok);
    repeat (10) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1 || bits !== 11'b1_1_10100110_0)
      $display("FAIL ignore_bits: got ok=%b %b want 1 11101001100", ok, bits);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL ignore_done: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ignore_no_restart: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    int inh_n, d0, e0;
    logic rts_ok, send_ok, ok;
    logic [10:0] bits;
    run_to_send(8'hED, inh_n, rts_ok, send_ok);
    dev_frame(1'b1, 5, 0, bits, ok);
    // After the 5th edge d4=0 is on the line, so data is being pulled.
    n_checks++;
    if (ps2_data_oe !== 1'b1 || busy !== 1'b1)
      $display("FAIL midrst_pre: got data_oe=%b busy=%b want 1 1", ps2_data_oe, busy);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b0)
      $display("FAIL midrst_async: got %b want 000", {ps2_clk_oe, ps2_data_oe, busy});
    else n_pass++;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    run_to_send(8'h81, inh_n, rts_ok, send_ok);
    n_checks++;
    if (inh_n !== INH || rts_ok !== 1'b1 || send_ok !== 1'b1)
      $display("FAIL midrst_restart: got inh=%0d rts=%b send=%b want %0d 1 1", inh_n, rts_ok, send_ok, INH);
    else n_pass++;
    dev_frame(1'b1, 0, 0, bits, ok);
    repeat (10) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1 || bits !== 11'b1_1_10000001_0)
      $display("FAIL midrst_bits: got ok=%b %b want 1 11100000010", ok, bits);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL midrst_done: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_exclusive;
    n_checks++;
    if (both_cnt !== 0) $display("FAIL done_err_overlap: got %0d want 0", both_cnt);
    else n_pass++;
    n_checks++;
    if (busy_bad !== 0) $display("FAIL busy_at_pulse: got %0d want 0", busy_bad);
    else n_pass++;
  endtask

  initial begin
    rst_n        = 1'b0;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    test_reset;
    test_send_ed;
    test_send_f4;
    test_no_ack;
    test_timeout;
    test_ignore_start;
    test_mid_reset;
    test_exclusive;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED for keyboard LEDs or 0xFF for reset, from the CPU side to the attached PS/2 device over the shared open-drain ps2_clk/ps2_data lines. It sits beside the PS/2 receiver: it drives the lines only while sending and releases them at all other times. Frame is start 0, 8 data bits LSB first, odd parity, stop 1, then a device ACK.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max clk cycles between consecutive device clock falling edges, and from clock release to first edge (15 ms at 50 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock line level (async)
ps2_data  in  1  raw PS/2 data line level (async)
ps2_clk_oe  out  1  1 = pull ps2_clk low; 0 = release
ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release
tx_data  in  8  byte to send; sampled when tx_start accepted
tx_start  in  1  one-cycle request; accepted only in IDLE
busy  out  1  high from the cycle after acceptance until return to IDLE
done  out  1  one-cycle pulse: frame sent and ACK received
err  out  1  one-cycle pulse: missing ACK or timeout

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0.
  - State IDLE; counters and shift register cleared.
  - Reset mid-frame releases both lines immediately (asynchronous).
- Input sync: ps2_clk and ps2_data each pass through a 2-FF synchronizer. A falling edge (fe) is the previous synced clk =1 and current =0. fe is therefore seen 3 clk cycles after the pad transition.
- Shift register: on acceptance it loads {1'b1 stop, ~^tx_data parity, tx_data}, 10 bits. The start bit is driven separately.
- ps2_data_oe = ~current_bit while a bit is being driven, so 0 bits pull low and 1 bits release.
- IDLE:
  - Both oe=0, busy=0.
  - tx_start=1 latches tx_data and moves to INHIBIT.
  - tx_start in any other state is ignored.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS:
  - One cycle with ps2_clk_oe=1 and ps2_data_oe=1 (start bit).
  - Then go to SEND with ps2_clk_oe=0 and ps2_data_oe=1; bit index =0.
  - The timeout counter is cleared on entry to SEND.
- SEND:
  - Each fe shifts the next bit onto data: fe 1..8 → d0..d7, fe 9 → parity, fe 10 → stop (data released). Then go to ACK.
  - Data changes in the cycle after fe is detected.
- ACK:
  - On the next fe (11th), sample synced ps2_data.
  - 0 → WAIT_IDLE.
  - 1 → err pulse, go to IDLE.
- WAIT_IDLE:
  - Wait until synced ps2_clk=1 and ps2_data=1 together.
  - Then pulse done for 1 cycle and go to IDLE.
- Timeout:
  - In SEND, ACK and WAIT_IDLE, a counter increments each cycle and clears on fe.
  - When it reaches TIMEOUT_CYCLES, release both lines, pulse err for 1 cycle, and go to IDLE.
- Exclusivity and busy:
  - done and err are never asserted together.
  - busy deasserts in the same cycle done or err pulses.
- Never drive the lines with both oe=0 outside IDLE except stop/ACK/WAIT_IDLE, where data is released by design.

Test Plan:
- Send 0xED with a device model clocking at ~12 kHz and ACKing → ps2_clk_oe low for 5000 cycles; line bits sampled on device rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; err=0.
- Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0; done pulses.
- Send 0x00 → parity 1; device model withholds ACK (data high at 11th fe) → err pulses; done never asserts; both oe=0 after.
- Device never clocks after RTS → err pulses exactly TIMEOUT_CYCLES cycles after clock release; lines released.
- tx_start pulsed again mid-frame with 0x55 → ignored; frame of the original byte completes unchanged.
- rst_n asserted after 5th fe → ps2_clk_oe=ps2_data_oe=busy=0 immediately; next tx_start after reset sends a complete clean frame.
